// File: rtl/inc_out_reg.sv
// rtl/inc_out_reg.sv - two-entry skid output register behind an incrementer
//
// Holds up to two words: a main register that drives out_data and a skid
// register that catches the word accepted while the main word is stalled.
// in_ready is registered, so out_ready never reaches it combinationally.
//
// Optional feature: define INC_OUT_REG_WRAP_FLAG_EN to add the wrap output.
// Each held word then carries a wrap bit, set when the word was zero at
// accept (the incrementer rolled over from all ones).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    incrementer result (DATAWIDTH bits)
//   in_valid   qualifies in_data
//   in_ready   stage can accept in_data this cycle (registered)
//   out_data   oldest held word (main register)
//   out_valid  qualifies out_data
//   out_ready  downstream takes out_data this cycle
//   level      held-word count: 0, 1 or 2
//   wrap       wrap bit of the main word while out_valid=1, else 0
//              (only with INC_OUT_REG_WRAP_FLAG_EN)

module inc_out_reg #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           level
`ifdef INC_OUT_REG_WRAP_FLAG_EN
    ,
    output logic                 wrap
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state;
    logic [DATAWIDTH-1:0]   main_q;
    logic [DATAWIDTH-1:0]   skid_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [1:0]             level_q;

    logic                   accept;
    logic                   emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign level     = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            level_q     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= in_data;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        level_q     <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        // Main word leaves while the new one replaces it.
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q     <= in_data;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                        level_q    <= 2'd2;
                    end else if (emit) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        level_q     <= 2'd0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only an emit can happen.
                    if (emit) begin
                        main_q     <= skid_q;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        level_q    <= 2'd1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    level_q     <= 2'd0;
                end
            endcase
        end
    end

`ifdef INC_OUT_REG_WRAP_FLAG_EN
    logic in_wrap;
    logic main_wrap_q;
    logic skid_wrap_q;

    assign in_wrap = (in_data == '0);
    assign wrap    = main_wrap_q & out_valid_q;

    // Wrap bits follow exactly the same moves as their data words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_wrap_q <= 1'b0;
            skid_wrap_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) main_wrap_q <= in_wrap;
                end
                ONE: begin
                    if (accept && emit) main_wrap_q <= in_wrap;
                    else if (accept)    skid_wrap_q <= in_wrap;
                end
                FULL: begin
                    if (emit) main_wrap_q <= skid_wrap_q;
                end
                default: begin
                    main_wrap_q <= 1'b0;
                    skid_wrap_q <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_inc_out_reg.sv
// tb/tb_inc_out_reg.sv - self-checking bench for inc_out_reg (DATAWIDTH=8)

module tb_inc_out_reg;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    level;
`ifdef INC_OUT_REG_WRAP_FLAG_EN
    logic          wrap;
`endif

    inc_out_reg #(.DATAWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
`ifdef INC_OUT_REG_WRAP_FLAG_EN
        ,
        .wrap      (wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          w;
    } ent_t;

    ent_t sb[$];
    int   mlevel;
    int   vectors;
    int   errors;
    int   emitted;

    // Scoreboard and occupancy model, evaluated mid-cycle when inputs are
    // stable; the model predicts what the next rising edge will do.
    always @(negedge clk) begin
        bit   acc;
        bit   em;
        ent_t e;
        if (rst) begin
            sb.delete();
            mlevel = 0;
            vectors++;
            if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_hold: ov=%b lvl=%0d ir=%b od=%h required ov=0 lvl=0 ir=1 od=00",
                         out_valid, level, in_ready, out_data);
            end
        end else begin
            vectors++;
            if (out_valid !== (mlevel > 0) || in_ready !== (mlevel < 2) || level !== mlevel[1:0]) begin
                errors++;
                $display("FAIL status: ov=%b ir=%b lvl=%0d required ov=%b ir=%b lvl=%0d",
                         out_valid, in_ready, level, (mlevel > 0), (mlevel < 2), mlevel);
            end
            if (mlevel > 0) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: model holds %0d words but queue empty", mlevel);
                end else if (out_data !== sb[0].d) begin
                    errors++;
                    $display("FAIL out_data: got %h required %h", out_data, sb[0].d);
                end
            end
`ifdef INC_OUT_REG_WRAP_FLAG_EN
            vectors++;
            if (wrap !== ((mlevel > 0 && sb.size() > 0) ? sb[0].w : 1'b0)) begin
                errors++;
                $display("FAIL wrap: got %b required %b", wrap,
                         (mlevel > 0 && sb.size() > 0) ? sb[0].w : 1'b0);
            end
`endif
            acc = in_valid && (mlevel < 2);
            em  = out_ready && (mlevel > 0);
            if (em && sb.size() > 0) begin
                e = sb.pop_front();
                emitted++;
            end
            if (acc) begin
                e.d = in_data;
                e.w = (in_data == '0);
                sb.push_back(e);
            end
            mlevel = mlevel + int'(acc) - int'(em);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        next_cycle();
        next_cycle();
        vectors++;
        if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL test_reset: ov=%b lvl=%0d ir=%b od=%h required 0 0 1 00",
                     out_valid, level, in_ready, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        in_data   = 8'h05;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h05) begin
            errors++;
            $display("FAIL test_single_latency: ov=%b od=%h required ov=1 od=05", out_valid, out_data);
        end
        next_cycle();
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL test_single_drop: ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_stream();
        int start;
        start     = emitted;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            next_cycle();
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL test_stream_ready: cycle %0d ir=%b required 1", i, in_ready);
            end
        end
        idle(2);
        vectors++;
        if (emitted - start !== 16) begin
            errors++;
            $display("FAIL test_stream_count: got %0d words required 16", emitted - start);
        end
    endtask

    task automatic test_backpressure();
        int start;
        start     = emitted;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA0;
        next_cycle();
        in_data = 8'hA1;
        next_cycle();
        in_data = 8'hA2;
        next_cycle();
        next_cycle();
        vectors++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL test_backpressure_full: lvl=%0d ir=%b od=%h required 2 0 a0",
                     level, in_ready, out_data);
        end
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        in_valid = 1'b0;
        idle(3);
        vectors++;
        if (emitted - start !== 3) begin
            errors++;
            $display("FAIL test_backpressure_count: got %0d words required 3", emitted - start);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB0;
        next_cycle();
        in_data = 8'hB1;
        next_cycle();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL test_reset_mid: ov=%b lvl=%0d ir=%b od=%h required 0 0 1 00",
                     out_valid, level, in_ready, out_data);
        end
        next_cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_data   = 8'hC0;
        in_valid  = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hC0) begin
            errors++;
            $display("FAIL test_reset_first: ov=%b od=%h required 1 c0", out_valid, out_data);
        end
        idle(3);
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        next_cycle();
        in_data = 8'h00;
        next_cycle();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL test_zero: ov=%b od=%h required 1 00", out_valid, out_data);
        end
`ifdef INC_OUT_REG_WRAP_FLAG_EN
        vectors++;
        if (wrap !== 1'b1) begin
            errors++;
            $display("FAIL test_zero_wrap: got %b required 1", wrap);
        end
`endif
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) in_data = 8'h00;
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
    endtask

    task automatic test_drain();
        vectors++;
        if (sb.size() !== 0 || level !== 2'd0) begin
            errors++;
            $display("FAIL test_drain: queue=%0d lvl=%0d required 0 0", sb.size(), level);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        emitted = 0;
        mlevel  = 0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_zero();
        test_random();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
